// File: rtl/uart_rx_ctrl.sv
// UART receiver controller: 16x tick divider, rdy/rdy_clr handshake and byte FIFO with valid/ready output.
// Optional idle-with-data timeout is built only when RX_TIMEOUT_EN is defined.
module uart_rx_ctrl #(
  parameter int unsigned FIFO_DEPTH    = 4,
  parameter int unsigned DIV_W         = 16,
  parameter int unsigned TIMEOUT_TICKS = 640
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              baud_div,
  output logic                          clk_en,
  input  logic                          rx_rdy,
  input  logic [7:0]                    rx_data,
  output logic                          rx_rdy_clr,
  output logic                          m_valid,
  output logic [7:0]                    m_data,
  input  logic                          m_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow,
  input  logic                          ovf_clr,
  output logic                          rx_timeout
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned PW = AW + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CLR  = 2'd1,
    WAIT = 2'd2
  } state_t;

  state_t            state, next_state;
  logic [DIV_W-1:0]  cnt;
  logic [PW-1:0]     wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic [7:0]        mem [FIFO_DEPTH];
  logic              push, pop, push_ok, full, empty;

  // Tick generator: >= compare lets a lowered baud_div take effect on the next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt    <= '0;
      clk_en <= 1'b0;
    end else if (!enable) begin
      cnt    <= '0;
      clk_en <= 1'b0;
    end else if (cnt >= baud_div) begin
      cnt    <= '0;
      clk_en <= 1'b1;
    end else begin
      cnt    <= cnt + 1'b1;
      clk_en <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    push       = 1'b0;
    unique case (state)
      IDLE: if (rx_rdy) begin
        next_state = CLR;
        push       = 1'b1;
      end
      CLR:  next_state = WAIT;
      WAIT: if (!rx_rdy) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign rx_rdy_clr = (state == CLR);

  assign empty      = (wr_ptr == rd_ptr);
  assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign m_valid    = !empty;
  assign m_data     = mem[rd_ptr[AW-1:0]];
  assign pop        = m_valid && m_ready;
  assign push_ok    = push && (!full || pop);
  assign fifo_count = wr_ptr - rd_ptr;
  assign wr_nxt     = push_ok ? wr_ptr + 1'b1 : wr_ptr;
  assign rd_nxt     = pop ? rd_ptr + 1'b1 : rd_ptr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      if (push_ok) mem[wr_ptr[AW-1:0]] <= rx_data;
    end
  end

  // A drop in the same cycle as ovf_clr keeps the flag set.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                overflow <= 1'b0;
    else if (push && !push_ok) overflow <= 1'b1;
    else if (ovf_clr)          overflow <= 1'b0;
  end

`ifdef RX_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_TICKS + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(TIMEOUT_TICKS);

  logic [TW-1:0] idle_cnt;

  // Clears on the same edge the FIFO drains, using the post-update pointers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_cnt   <= '0;
      rx_timeout <= 1'b0;
    end else if (push_ok || empty || (wr_nxt == rd_nxt)) begin
      idle_cnt   <= '0;
      rx_timeout <= 1'b0;
    end else begin
      if (clk_en && (idle_cnt != TO_MAX)) idle_cnt <= idle_cnt + 1'b1;
      if (idle_cnt == TO_MAX) rx_timeout <= 1'b1;
    end
  end
`else
  assign rx_timeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed self-checking bench for uart_rx_ctrl: tick divider, handshake, FIFO, overflow, timeout and reset.
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       enable;
  logic [15:0] baud_div;
  logic       clk_en;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       rx_rdy_clr;
  logic       m_valid;
  logic [7:0] m_data;
  logic       m_ready;
  logic [2:0] fifo_count;
  logic       overflow;
  logic       ovf_clr;
  logic       rx_timeout;

  int errors = 0;
  int checks = 0;

  uart_rx_ctrl #(
    .FIFO_DEPTH   (4),
    .DIV_W        (16),
    .TIMEOUT_TICKS(8)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .baud_div  (baud_div),
    .clk_en    (clk_en),
    .rx_rdy    (rx_rdy),
    .rx_data   (rx_data),
    .rx_rdy_clr(rx_rdy_clr),
    .m_valid   (m_valid),
    .m_data    (m_data),
    .m_ready   (m_ready),
    .fifo_count(fifo_count),
    .overflow  (overflow),
    .ovf_clr   (ovf_clr),
    .rx_timeout(rx_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    step();
    rx_rdy  = 1'b0;
    step();
    step();
  endtask

  task automatic drain_check(input string tag, input logic [7:0] exp);
    check({tag, "_valid"}, m_valid, 1);
    check({tag, "_data"}, m_data, exp);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
  endtask

  logic [7:0] exp_q [4];

  initial begin
    rst_n = 1'b0; enable = 1'b0; baud_div = 16'd3; rx_rdy = 1'b0;
    rx_data = 8'h00; m_ready = 1'b0; ovf_clr = 1'b0;
    step(); step();
    check("rst_clk_en", clk_en, 0);
    check("rst_rdy_clr", rx_rdy_clr, 0);
    check("rst_valid", m_valid, 0);
    check("rst_count", fifo_count, 0);
    check("rst_ovf", overflow, 0);
    rst_n = 1'b1;
    step();

    // Tick: period 4 with baud_div=3
    enable = 1'b1;
    begin
      int n = 0;
      while (clk_en !== 1'b1 && n < 20) begin step(); n++; end
      check("tick_found", clk_en, 1);
    end
    step(); check("tick_p1", clk_en, 0);
    step(); check("tick_p2", clk_en, 0);
    step(); check("tick_p3", clk_en, 0);
    step(); check("tick_p4", clk_en, 1);
    step(); step();
    baud_div = 16'd1;
    step(); check("tick_lower", clk_en, 1);
    step(); check("tick_b1_0", clk_en, 0);
    step(); check("tick_b1_1", clk_en, 1);

    // Single byte held two cycles
    rx_data = 8'hA5; rx_rdy = 1'b1;
    check("sb_pre_valid", m_valid, 0);
    step();
    check("sb_clr", rx_rdy_clr, 1);
    check("sb_valid", m_valid, 1);
    check("sb_data", m_data, 8'hA5);
    check("sb_count", fifo_count, 1);
    step();
    check("sb_clr_low", rx_rdy_clr, 0);
    rx_rdy = 1'b0;
    step(); step();
    check("sb_no_dup", fifo_count, 1);
    check("sb_clr_idle", rx_rdy_clr, 0);
    drain_check("sb_drain", 8'hA5);
    check("sb_empty", m_valid, 0);

    // Overflow: five bytes into depth-4 FIFO
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    check("ovf_count", fifo_count, 4);
    check("ovf_flag", overflow, 1);
    for (int i = 1; i <= 4; i++) drain_check("ovf_drain", 8'(i));
    check("ovf_empty", fifo_count, 0);
    check("ovf_sticky", overflow, 1);
    ovf_clr = 1'b1; step(); ovf_clr = 1'b0;
    check("ovf_clr", overflow, 0);

    // Full FIFO with a pop in the same cycle as a push
    for (int i = 0; i < 4; i++) send_byte(8'h10 + 8'(i));
    check("fs_full", fifo_count, 4);
    rx_data = 8'h77; rx_rdy = 1'b1; m_ready = 1'b1;
    step();
    m_ready = 1'b0; rx_rdy = 1'b0;
    check("fs_ovf", overflow, 0);
    check("fs_count", fifo_count, 4);
    check("fs_clr", rx_rdy_clr, 1);
    step(); step();
    exp_q = '{8'h11, 8'h12, 8'h13, 8'h77};
    for (int i = 0; i < 4; i++) drain_check("fs_drain", exp_q[i]);
    check("fs_empty", m_valid, 0);

    // Timeout: tick every cycle
    baud_div = 16'd0;
    send_byte(8'h3C);
    check("to_early", rx_timeout, 0);
    for (int i = 0; i < 12; i++) step();
`ifdef RX_TIMEOUT_EN
    check("to_set", rx_timeout, 1);
`else
    check("to_set", rx_timeout, 0);
`endif
    drain_check("to_drain", 8'h3C);
    check("to_clear", rx_timeout, 0);

    // Reset mid-frame: 2 bytes queued plus one in WAIT
    send_byte(8'hB1);
    send_byte(8'hB2);
    rx_data = 8'hB3; rx_rdy = 1'b1;
    step(); step();
    check("mr_count_pre", fifo_count, 3);
    rst_n = 1'b0;
    #1;
    check("mr_clk_en", clk_en, 0);
    check("mr_clr", rx_rdy_clr, 0);
    check("mr_valid", m_valid, 0);
    check("mr_data", m_data, 0);
    check("mr_count", fifo_count, 0);
    check("mr_ovf", overflow, 0);
    check("mr_to", rx_timeout, 0);
    rx_rdy = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    check("mr_count_post", fifo_count, 0);
    rx_data = 8'h5A; rx_rdy = 1'b1;
    step();
    rx_rdy = 1'b0;
    check("mr_idle_clr", rx_rdy_clr, 1);
    check("mr_idle_data", m_data, 8'h5A);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
